oai31_bist_seq: RTL

- Built-in self-test sequencer that sits around one oai31 cell instance on a library validation chip.
- Upstream role: drives the cell inputs A1, A2, A3 and B with an exhaustive 16-vector sweep.
- Downstream role: samples the cell's ZN output and checks it against the function ZN = !((A1|A2|A3)&B).
- Reports pass/fail, a saturating mismatch count and the first failing vector to the test controller.

---
 rtl/oai31_bist_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/oai31_bist_seq.sv
// oai31_bist_seq: exhaustive 16-vector BIST sequencer for a single oai31 cell.
// Drives {A1,A2,A3,B} with the vector index, samples ZN_IN after a settle time
// and checks it against ZN = !((A1|A2|A3)&B). It reports pass/fail, a
// saturating mismatch count and the index of the first failing vector.
module oai31_bist_seq #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ZN_IN,
    output logic                 A1,
    output logic                 A2,
    output logic                 A3,
    output logic                 B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [ERR_CNT_W-1:0] ERR_CNT,
    output logic [3:0]           FAIL_VEC
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [7:0]           SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]           PASS_LAST   = 8'(NUM_PASSES - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = {ERR_CNT_W{1'b1}};

    state_t               state_reg, state_next;
    logic [3:0]           idx_reg, idx_next;
    logic [7:0]           settle_reg, settle_next;
    logic [7:0]           pass_reg, pass_next;
    logic [ERR_CNT_W-1:0] err_reg, err_next;
    logic [3:0]           fail_vec_reg, fail_vec_next;

    logic                 exp_bit;
    logic                 mismatch;
    logic                 stim_active;
    logic [3:0]           stim;

    // Golden oai31 response for the current vector; an unknown ZN counts as a miss.
    assign exp_bit  = ~((idx_reg[3] | idx_reg[2] | idx_reg[1]) & idx_reg[0]);
    assign mismatch = (ZN_IN !== exp_bit);

    // State register and datapath registers; reset clears any half-finished run.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= 4'd0;
            settle_reg   <= 8'd0;
            pass_reg     <= 8'd0;
            err_reg      <= '0;
            fail_vec_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            settle_reg   <= settle_next;
            pass_reg     <= pass_next;
            err_reg      <= err_next;
            fail_vec_reg <= fail_vec_next;
        end
    end

    // Next-state logic: sweep vectors, settle, sample, and accumulate errors.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        settle_next   = settle_reg;
        pass_next     = pass_reg;
        err_next      = err_reg;
        fail_vec_next = fail_vec_reg;

        case (state_reg)
            ST_IDLE, ST_FINISH: begin
                if (START) begin
                    state_next    = ST_SETTLE;
                    idx_next      = 4'd0;
                    settle_next   = 8'd0;
                    pass_next     = 8'd0;
                    err_next      = '0;
                    fail_vec_next = 4'd0;
                end
            end
            ST_SETTLE: begin
                settle_next = settle_reg + 8'd1;
                if (settle_reg == SETTLE_LAST) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_reg != ERR_MAX) begin
                        err_next = err_reg + 1'b1;
                    end
                    // Only the first miss of a run is recorded.
                    if (err_reg == '0) begin
                        fail_vec_next = idx_reg;
                    end
                end
                settle_next = 8'd0;
                if (idx_reg == 4'd15 && pass_reg == PASS_LAST) begin
                    state_next = ST_FINISH;
                end else if (idx_reg == 4'd15) begin
                    idx_next   = 4'd0;
                    pass_next  = pass_reg + 8'd1;
                    state_next = ST_SETTLE;
                end else begin
                    idx_next   = idx_reg + 4'd1;
                    state_next = ST_SETTLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign stim_active = (state_reg == ST_SETTLE) || (state_reg == ST_SAMPLE);

    // Stimulus is the vector index while running and forced low otherwise.
    for (genvar gi = 0; gi < 4; gi++) begin : g_stim
        assign stim[gi] = stim_active & idx_reg[gi];
    end

    assign A1       = stim[3];
    assign A2       = stim[2];
    assign A3       = stim[1];
    assign B        = stim[0];
    assign BUSY     = stim_active;
    assign DONE     = (state_reg == ST_FINISH);
    assign PASS     = (state_reg == ST_FINISH) && (err_reg == '0);
    assign ERR_CNT  = err_reg;
    assign FAIL_VEC = fail_vec_reg;

endmodule
